pipe_skid_reg: RTL and testbench

//  Parametrised pipeline-stage register with a valid/ready handshake and a two-entry skid buffer.

---
 rtl/pipe_skid_reg_pkg.sv | 13 +
 rtl/pipe_skid_reg_register_nbit_cen.sv | 37 +++
 rtl/pipe_skid_reg.sv | 118 +++++++++++
 tb/tb_pipe_skid_reg.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
// State encoding and the RV32I NOP used as the default flush bubble.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } state_e;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_reg_register_nbit_cen.sv
// N-bit register with clock enable, synchronous clear-to-value and async active-low reset.
// Clear takes priority over the enable.
module pipe_skid_reg_register_nbit_cen #(
    parameter int unsigned       WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Clr_val,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Out
);

    logic [WIDTH-1:0] val_d, val_q;

    always_comb begin
        val_d = val_q;
        if (Clear) begin
            val_d = Clr_val;
        end else if (En) begin
            val_d = D;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign Out = val_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// In_ready decodes the state flop only, so no combinational path from Out_ready.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [31:0]      FLUSH_VAL = NopInstr,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic             Flush,
    output logic [WIDTH-1:0] Out,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [CNT_W-1:0] Stall_count
);

    localparam logic [WIDTH-1:0] FlushValW = WIDTH'(FLUSH_VAL);

    state_e           state_d, state_q;
    logic             in_fire, out_fire;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_din, skid_out;
    logic [CNT_W-1:0] stall_d, stall_q;

    assign In_ready  = (state_q != StSkid);
    assign Out_valid = (state_q != StEmpty);
    assign in_fire   = In_valid & In_ready;
    assign out_fire  = Out_valid & Out_ready;

    always_comb begin
        state_d  = state_q;
        main_en  = 1'b0;
        skid_en  = 1'b0;
        main_din = D;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StFull;
                    main_en = 1'b1;
                end
            end
            StFull: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = StSkid;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StSkid: begin
                // Skid entry is the younger one; it moves up once main drains.
                if (out_fire) begin
                    state_d  = StFull;
                    main_en  = 1'b1;
                    main_din = skid_out;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (Flush) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (Out_valid && !Out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StEmpty;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    pipe_skid_reg_register_nbit_cen #(
        .WIDTH   (WIDTH),
        .RST_VAL (RESET_VAL)
    ) u_main (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .En      (main_en),
        .Clear   (Flush),
        .Clr_val (FlushValW),
        .D       (main_din),
        .Out     (Out)
    );

    pipe_skid_reg_register_nbit_cen #(
        .WIDTH   (WIDTH),
        .RST_VAL (RESET_VAL)
    ) u_skid (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .En      (skid_en),
        .Clear   (Flush),
        .Clr_val (FlushValW),
        .D       (D),
        .Out     (skid_out)
    );

    assign Stall_count = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg against a queue-based reference model.
module tb_pipe_skid_reg;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] D;
    logic        In_valid;
    logic        In_ready;
    logic        Flush;
    logic [31:0] Out;
    logic        Out_valid;
    logic        Out_ready;
    logic [3:0]  Stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ordered list of held entries plus the value Out shows when empty.
    logic [31:0] mq[$];
    logic [31:0] m_last;
    int          m_cnt;

    pipe_skid_reg #(
        .WIDTH (32),
        .CNT_W (4)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .D           (D),
        .In_valid    (In_valid),
        .In_ready    (In_ready),
        .Flush       (Flush),
        .Out         (Out),
        .Out_valid   (Out_valid),
        .Out_ready   (Out_ready),
        .Stall_count (Stall_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = 32'h0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic fl);
        int sz;
        bit inf, outf;
        sz   = mq.size();
        inf  = iv && (sz < 2);
        outf = ordy && (sz > 0);
        if (sz > 0 && !ordy && m_cnt < 15) m_cnt++;
        if (fl) begin
            mq.delete();
            m_last = 32'h0000_0013;
        end else begin
            if (outf) m_last = mq.pop_front();
            if (inf) mq.push_back(d);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_out;
        exp_out = (mq.size() > 0) ? mq[0] : m_last;
        check_eq("out_valid", {31'b0, Out_valid}, {31'b0, (mq.size() > 0)});
        check_eq("in_ready", {31'b0, In_ready}, {31'b0, (mq.size() < 2)});
        check_eq("out", Out, exp_out);
        check_eq("stall_count", {28'b0, Stall_count}, m_cnt);
    endtask

    // Drive inputs, compare mid-cycle, then advance the model across the rising edge.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        In_valid  = iv;
        D         = d;
        Out_ready = ordy;
        Flush     = fl;
        @(negedge Clk);
        check_outputs();
        @(posedge Clk);
        model_step(iv, d, ordy, fl);
        #1;
    endtask

    task automatic reset_pulse();
        #1 Rst_n = 1'b0;
        #1;
        check_eq("rst_out", Out, 32'h0);
        check_eq("rst_out_valid", {31'b0, Out_valid}, 32'h0);
        check_eq("rst_in_ready", {31'b0, In_ready}, 32'h1);
        check_eq("rst_stall", {28'b0, Stall_count}, 32'h0);
        model_reset();
        #1 Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n     = 1'b1;
        D         = '0;
        In_valid  = 1'b0;
        Out_ready = 1'b0;
        Flush     = 1'b0;
        model_reset();

        // Reset before any clock edge
        reset_pulse();
        @(posedge Clk);
        #1;

        // Streaming
        for (int i = 1; i <= 6; i++) cycle(1'b1, i, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Skid: accept A, stall, offer B, then drain
        cycle(1'b1, 32'hAAAA_0001, 1'b1, 1'b0);
        cycle(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while in skid with a new offer pending
        cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        cycle(1'b1, 32'hCCCC_CCCC, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("flush_out", Out, 32'h0000_0013);

        // Saturating stall counter
        reset_pulse();
        cycle(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("stall_sat", {28'b0, Stall_count}, 32'd15);

        // Async reset while full, between edges
        reset_pulse();
        cycle(1'b1, 32'h7777_0007, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        reset_pulse();
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
